decryption_cfg_arbiter: RTL and testbench

//   Shares the decryption register bank access port between two requesters.

---
 rtl/decryption_cfg_arbiter_if.sv | 54 +++++
 rtl/decryption_cfg_arbiter.sv | 121 ++++++++++++
 tb/tb_decryption_cfg_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decryption_cfg_arbiter_if.sv
// Bundle of the two requester ports and the register-bank port of the decryption config arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and bank's view.
interface decryption_cfg_arbiter_if #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16
);
  logic                  req0_valid;
  logic                  req0_write;
  logic [addr_width-1:0] req0_addr;
  logic [reg_width-1:0]  req0_wdata;
  logic                  req0_ready;
  logic                  resp0_valid;
  logic [reg_width-1:0]  resp0_rdata;
  logic                  resp0_error;

  logic                  req1_valid;
  logic                  req1_write;
  logic [addr_width-1:0] req1_addr;
  logic [reg_width-1:0]  req1_wdata;
  logic                  req1_ready;
  logic                  resp1_valid;
  logic [reg_width-1:0]  resp1_rdata;
  logic                  resp1_error;

  logic [addr_width-1:0] rf_addr;
  logic                  rf_read;
  logic                  rf_write;
  logic [reg_width-1:0]  rf_wdata;
  logic [reg_width-1:0]  rf_rdata;
  logic                  rf_done;
  logic                  rf_error;

  logic                  busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, resp0_valid, resp0_rdata, resp0_error,
    output req1_ready, resp1_valid, resp1_rdata, resp1_error,
    output rf_addr, rf_read, rf_write, rf_wdata,
    input  rf_rdata, rf_done, rf_error,
    output busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, resp0_valid, resp0_rdata, resp0_error,
    input  req1_ready, resp1_valid, resp1_rdata, resp1_error,
    input  rf_addr, rf_read, rf_write, rf_wdata,
    output rf_rdata, rf_done, rf_error,
    input  busy
  );
endinterface

// File: rtl/decryption_cfg_arbiter.sv
// Two-port arbiter for the decryption register bank: one transaction at a time,
// issue pulse, wait for done (or timeout), then a one-cycle response to the granted port.
module decryption_cfg_arbiter #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 8
) (
  input logic                    clk,
  input logic                    rst,
  decryption_cfg_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  last_grant;
  logic                  grant_port;
  logic                  hs0, hs1, handshake;
  logic                  cur_port, cur_write;
  logic [addr_width-1:0] cur_addr;
  logic [reg_width-1:0]  cur_wdata;
  logic [reg_width-1:0]  resp_rdata, resp_rdata_next;
  logic                  resp_error, resp_error_next;

  // Round-robin favours the port that did not win last; last_grant resets to 1 so port 0 wins the first tie.
  always_comb begin
    grant_port = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (bus.req1_valid)
      grant_port = 1'b1;
  end

  assign hs0       = (state == IDLE) && bus.req0_valid && !grant_port;
  assign hs1       = (state == IDLE) && bus.req1_valid &&  grant_port;
  assign handshake = hs0 || hs1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cur_write  <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      resp_rdata <= resp_rdata_next;
      resp_error <= resp_error_next;
      if (handshake) begin
        last_grant <= grant_port;
        cur_port   <= grant_port;
        cur_write  <= grant_port ? bus.req1_write : bus.req0_write;
        cur_addr   <= grant_port ? bus.req1_addr  : bus.req0_addr;
        cur_wdata  <= grant_port ? bus.req1_wdata : bus.req0_wdata;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    resp_rdata_next = resp_rdata;
    resp_error_next = resp_error;
    case (state)
      IDLE: begin
        if (handshake) state_next = ISSUE;
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt + 1'b1;
        if (bus.rf_done) begin
          resp_error_next = bus.rf_error;
          resp_rdata_next = (!cur_write && !bus.rf_error) ? bus.rf_rdata : '0;
          state_next      = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // The TIMEOUT-th WAIT cycle without done aborts the transaction.
          resp_error_next = 1'b1;
          resp_rdata_next = '0;
          state_next      = RESP;
        end
      end
      RESP: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req0_ready  = hs0;
  assign bus.req1_ready  = hs1;

  assign bus.rf_read     = (state == ISSUE) && !cur_write;
  assign bus.rf_write    = (state == ISSUE) &&  cur_write;
  assign bus.rf_addr     = cur_addr;
  assign bus.rf_wdata    = cur_wdata;

  assign bus.resp0_valid = (state == RESP) && !cur_port;
  assign bus.resp1_valid = (state == RESP) &&  cur_port;
  assign bus.resp0_rdata = bus.resp0_valid ? resp_rdata : '0;
  assign bus.resp1_rdata = bus.resp1_valid ? resp_rdata : '0;
  assign bus.resp0_error = bus.resp0_valid && resp_error;
  assign bus.resp1_error = bus.resp1_valid && resp_error;

  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_decryption_cfg_arbiter.sv
// Directed bench for decryption_cfg_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration, dropped requests, stray done and mid-transaction reset.
module tb_decryption_cfg_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decryption_cfg_arbiter_if #(.addr_width(8), .reg_width(16)) bus ();
  decryption_cfg_arbiter_if #(.addr_width(8), .reg_width(16)) bus_fp ();

  decryption_cfg_arbiter #(.addr_width(8), .reg_width(16), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  decryption_cfg_arbiter #(.addr_width(8), .reg_width(16), .FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Register bank model: done/error registered one cycle after the pulse, done held high in reset.
  logic [15:0] mem [256];
  logic bank_err   = 1'b0;
  logic bank_mute  = 1'b0;
  logic force_done = 1'b0;
  int   bad_issue  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_done  <= 1'b1;
      bus.rf_error <= 1'b0;
      bus.rf_rdata <= '0;
    end else begin
      bus.rf_done  <= ((bus.rf_read || bus.rf_write) && !bank_mute) || force_done;
      bus.rf_error <= (bus.rf_read || bus.rf_write) && bank_err;
      if (bus.rf_read) bus.rf_rdata <= mem[bus.rf_addr];
      if (bus.rf_write && !bank_err) mem[bus.rf_addr] <= bus.rf_wdata;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_fp.rf_done  <= 1'b0;
      bus_fp.rf_error <= 1'b0;
      bus_fp.rf_rdata <= '0;
    end else begin
      bus_fp.rf_done  <= bus_fp.rf_read || bus_fp.rf_write;
    end
  end

  always @(posedge clk) begin
    if ((bus.rf_read || bus.rf_write) && bus.rf_addr == 8'h77) bad_issue <= bad_issue + 1;
  end

  typedef struct {
    logic        port;
    logic        write;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        err;
    logic        mute;
    logic [15:0] exp_rdata;
    logic        exp_error;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic port, input logic valid, input logic write,
                         input logic [7:0] addr, input logic [15:0] wdata);
    if (port) begin
      bus.req1_valid = valid; bus.req1_write = write; bus.req1_addr = addr; bus.req1_wdata = wdata;
    end else begin
      bus.req0_valid = valid; bus.req0_write = write; bus.req0_addr = addr; bus.req0_wdata = wdata;
    end
  endtask

  task automatic drop_all();
    bus.req0_valid    = 1'b0;
    bus.req1_valid    = 1'b0;
    bus_fp.req0_valid = 1'b0;
    bus_fp.req1_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    @(negedge clk);
    bank_err  = v.err;
    bank_mute = v.mute;
    set_req(v.port, 1'b1, v.write, v.addr, v.wdata);
    #1;
    check($sformatf("v%0d ready", idx), v.port ? bus.req1_ready : bus.req0_ready, 1);
    check($sformatf("v%0d other ready", idx), v.port ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    drop_all();
    #1;
    check($sformatf("v%0d rf_read", idx), bus.rf_read, !v.write);
    check($sformatf("v%0d rf_write", idx), bus.rf_write, v.write);
    check($sformatf("v%0d rf_addr", idx), bus.rf_addr, v.addr);
    if (v.write) check($sformatf("v%0d rf_wdata", idx), bus.rf_wdata, v.wdata);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      if (bus.resp0_valid || bus.resp1_valid) got = 1'b1;
      else if (lat == 1) begin
        check($sformatf("v%0d wait pulse", idx), {bus.rf_read, bus.rf_write}, 0);
        check($sformatf("v%0d wait addr", idx), bus.rf_addr, v.addr);
      end
    end
    check($sformatf("v%0d latency", idx), lat, v.mute ? 9 : 2);
    check($sformatf("v%0d resp valid", idx), v.port ? bus.resp1_valid : bus.resp0_valid, 1);
    check($sformatf("v%0d other resp", idx), v.port ? bus.resp0_valid : bus.resp1_valid, 0);
    check($sformatf("v%0d rdata", idx), v.port ? bus.resp1_rdata : bus.resp0_rdata, v.exp_rdata);
    check($sformatf("v%0d error", idx), v.port ? bus.resp1_error : bus.resp0_error, v.exp_error);
    @(negedge clk);
    #1;
    check($sformatf("v%0d idle", idx), bus.busy, 0);
    check($sformatf("v%0d resp cleared", idx),
          {bus.resp0_valid, bus.resp1_valid, bus.resp0_error, bus.resp1_error,
           |bus.resp0_rdata, |bus.resp1_rdata}, 0);
    bank_err  = 1'b0;
    bank_mute = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  saw_resp;
    //              port  wr    addr   wdata     err   mute  rdata     error
    vecs[0] = '{1'b0, 1'b1, 8'h10, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h05, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 8'h30, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    bus_fp.req0_valid = 1'b0; bus_fp.req0_write = 1'b1; bus_fp.req0_addr = 8'h40; bus_fp.req0_wdata = 16'h1111;
    bus_fp.req1_valid = 1'b0; bus_fp.req1_write = 1'b1; bus_fp.req1_addr = 8'h41; bus_fp.req1_wdata = 16'h2222;
    #1;
    check("reset outputs",
          {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_error,
           bus.resp1_error, |bus.resp0_rdata, |bus.resp1_rdata, bus.rf_read, bus.rf_write,
           |bus.rf_addr, |bus.rf_wdata, bus.busy}, 0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    #1;
    check("idle after reset with bank done", {bus.busy, bus.resp0_valid, bus.resp1_valid}, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both ports held valid: round-robin alternates, fixed priority keeps port 0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 8'h40, 16'h1111);
    set_req(1'b1, 1'b1, 1'b1, 8'h41, 16'h2222);
    bus_fp.req0_valid = 1'b1;
    bus_fp.req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      if (k > 0) begin
        @(negedge clk);
        #1;
        cyc = 1;
      end
      while (!(bus.req0_ready || bus.req1_ready) && cyc < 10) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      if (k > 0) check($sformatf("rr spacing %0d", k), cyc, 4);
      check($sformatf("rr grant %0d", k), {bus.req1_ready, bus.req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("fp grant %0d", k), {bus_fp.req1_ready, bus_fp.req0_ready}, 2'b01);
    end
    @(negedge clk);
    drop_all();
    idle_cycles(5);
    #1;
    check("arb idle", {bus.busy, bus_fp.busy}, 0);

    // A request raised while busy and dropped before ready must never reach the bank.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 8'h50, 16'h5555);
    #1;
    check("busy-test ready0", bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 8'h77, 16'h7777);
    #1;
    check("busy ready1 issue", bus.req1_ready, 0);
    @(negedge clk);
    #1;
    check("busy ready1 wait", bus.req1_ready, 0);
    bus.req1_valid = 1'b0;
    idle_cycles(6);
    #1;
    check("dropped request not issued", bad_issue, 0);

    // Stray done while idle is ignored.
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.resp0_valid || bus.resp1_valid || bus.busy) saw_resp = 1'b1;
      @(negedge clk);
    end
    check("stray done ignored", saw_resp, 0);

    // Reset during ISSUE: the bank pulse falls immediately.
    set_req(1'b1, 1'b1, 1'b1, 8'h60, 16'h6666);
    #1;
    check("rst-issue ready", bus.req1_ready, 1);
    @(negedge clk);
    drop_all();
    #1;
    check("rst-issue pulse before", bus.rf_write, 1);
    rst = 1'b1;
    #1;
    check("rst-issue pulse falls", {bus.rf_write, bus.rf_read, bus.busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during WAIT: transaction dropped, no response, next request served.
    @(negedge clk);
    bank_mute = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 8'h40, 16'h0000);
    #1;
    check("rst-wait ready", bus.req0_ready, 1);
    @(negedge clk);
    drop_all();
    @(negedge clk);
    #1;
    check("rst-wait busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rst-wait outputs",
          {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp0_error,
           bus.resp1_error, |bus.resp0_rdata, |bus.resp1_rdata, bus.rf_read, bus.rf_write,
           |bus.rf_addr, |bus.rf_wdata, bus.busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    bank_mute = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (bus.resp0_valid || bus.resp1_valid || bus.busy) saw_resp = 1'b1;
    end
    check("no resp after reset", saw_resp, 0);

    // First tie after reset goes to port 0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 8'h42, 16'h4242);
    set_req(1'b1, 1'b1, 1'b1, 8'h43, 16'h4343);
    #1;
    check("first tie", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(negedge clk);
    drop_all();
    idle_cycles(4);
    #1;
    check("tie txn done", bus.busy, 0);

    run_vec('{1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b0}, 8);
    run_vec('{1'b0, 1'b0, 8'h42, 16'h0000, 1'b0, 1'b0, 16'h4242, 1'b0}, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
